alarm_controller: RTL and testbench

- Alarm scheduler for the digital clock. It holds a BCD alarm time (HH:MM) and runs its own setting sequence on the shared sel/inc button pulses.
- It compares the alarm time against the running BCD time from the clock counter. On a match it sequences a ring / snooze / stop cycle that drives the buzzer.
- Its outputs go to the display path (alarm time, blink select) and to the buzzer pin.

---
 rtl/alarm_controller.sv | 163 ++++++++++++++++
 tb/tb_alarm_controller.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/alarm_controller.sv
// Alarm scheduler: holds a BCD HH:MM alarm, edits it with sel/inc pulses, and runs
// the ring / snooze / stop sequence when the running time reaches the alarm.
module alarm_controller #(
  parameter int RING_SECONDS   = 60,
  parameter int SNOOZE_SECONDS = 300,
  parameter int MAX_SNOOZE     = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_1hz_tick,
  input  logic [7:0] cur_hh,
  input  logic [7:0] cur_mm,
  input  logic [7:0] cur_ss,
  input  logic       clk_set_en,
  input  logic       alm_p,
  input  logic       sel_p,
  input  logic       inc_p,
  input  logic       stop_p,
  input  logic       snooze_p,
  output logic       alm_set_en,
  output logic [7:0] alm_hh,
  output logic [7:0] alm_mm,
  output logic [1:0] blink_sel,
  output logic       armed,
  output logic       ringing,
  output logic       buzzer
);
  localparam int RW = $clog2(RING_SECONDS) + 1;
  localparam int TW = $clog2(SNOOZE_SECONDS) + 1;
  localparam int SW = $clog2(MAX_SNOOZE) + 1;

  typedef enum logic [2:0] {IDLE, SET_HH, SET_MM, RING, SNOOZE} state_t;

  state_t        r_state, w_state_n;
  logic [7:0]    r_alm_hh, w_alm_hh_n, r_alm_mm, w_alm_mm_n;
  logic          r_armed, w_armed_n;
  logic          r_match_d, w_match, w_trig;
  logic [RW-1:0] r_ring_cnt, w_ring_cnt_n;
  logic [TW-1:0] r_snz_tmr, w_snz_tmr_n;
  logic [SW-1:0] r_snz_cnt, w_snz_cnt_n;
  logic          r_beep, w_beep_n;
  logic          r_set_en, r_ringing, r_buzzer;
  logic [1:0]    r_blink, w_blink_n;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
    if (v == vmax)          return 8'h00;
    else if (v[3:0] == 4'h9) return {v[7:4] + 4'h1, 4'h0};
    else                     return {v[7:4], v[3:0] + 4'h1};
  endfunction

  assign w_match = (cur_hh == r_alm_hh) && (cur_mm == r_alm_mm) && (cur_ss == 8'h00);
  // Only the rising edge counts, so a held match level cannot re-enter RING.
  assign w_trig  = w_match && !r_match_d && (r_state == IDLE) && r_armed && !clk_set_en;

  always_comb begin
    w_state_n    = r_state;
    w_alm_hh_n   = r_alm_hh;
    w_alm_mm_n   = r_alm_mm;
    w_armed_n    = r_armed;
    w_ring_cnt_n = r_ring_cnt;
    w_snz_tmr_n  = r_snz_tmr;
    w_snz_cnt_n  = r_snz_cnt;
    w_beep_n     = r_beep;
    unique case (r_state)
      IDLE: begin
        if (w_trig) begin
          w_state_n    = RING;
          w_ring_cnt_n = '0;
          w_snz_cnt_n  = '0;
          w_beep_n     = 1'b1;
        end else begin
          if (alm_p && !clk_set_en) w_state_n = SET_HH;
          if (snooze_p)             w_armed_n = ~r_armed;
        end
      end
      SET_HH, SET_MM: begin
        if (alm_p) begin
          w_state_n = IDLE;
          w_armed_n = 1'b1;
        end else if (sel_p) begin
          w_state_n = (r_state == SET_HH) ? SET_MM : SET_HH;
        end else if (inc_p) begin
          if (r_state == SET_HH) w_alm_hh_n = bcd_inc(r_alm_hh, 8'h23);
          else                   w_alm_mm_n = bcd_inc(r_alm_mm, 8'h59);
        end
      end
      RING: begin
        if (stop_p) begin
          w_state_n = IDLE;
        end else if (snooze_p && (r_snz_cnt < SW'(MAX_SNOOZE))) begin
          w_state_n   = SNOOZE;
          w_snz_cnt_n = r_snz_cnt + 1'b1;
          w_snz_tmr_n = '0;
        end else if (clk_1hz_tick) begin
          w_beep_n = ~r_beep;
          if (r_ring_cnt != RW'(RING_SECONDS)) w_ring_cnt_n = r_ring_cnt + 1'b1;
          if (r_ring_cnt >= RW'(RING_SECONDS - 1)) w_state_n = IDLE;
        end
      end
      SNOOZE: begin
        if (stop_p) begin
          w_state_n = IDLE;
        end else if (clk_1hz_tick) begin
          if (r_snz_tmr != TW'(SNOOZE_SECONDS)) w_snz_tmr_n = r_snz_tmr + 1'b1;
          if (r_snz_tmr >= TW'(SNOOZE_SECONDS - 1)) begin
            w_state_n    = RING;
            w_ring_cnt_n = '0;
            w_beep_n     = 1'b1;
          end
        end
      end
      default: w_state_n = IDLE;
    endcase
  end

  always_comb begin
    w_blink_n = 2'b11;
    if (w_state_n == SET_HH)      w_blink_n = 2'b00;
    else if (w_state_n == SET_MM) w_blink_n = 2'b01;
  end

  // Display/buzzer outputs are registered from the next-state values so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_alm_hh   <= 8'h00;
      r_alm_mm   <= 8'h00;
      r_armed    <= 1'b0;
      r_match_d  <= 1'b0;
      r_ring_cnt <= '0;
      r_snz_tmr  <= '0;
      r_snz_cnt  <= '0;
      r_beep     <= 1'b0;
      r_set_en   <= 1'b0;
      r_blink    <= 2'b11;
      r_ringing  <= 1'b0;
      r_buzzer   <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_alm_hh   <= w_alm_hh_n;
      r_alm_mm   <= w_alm_mm_n;
      r_armed    <= w_armed_n;
      r_match_d  <= w_match;
      r_ring_cnt <= w_ring_cnt_n;
      r_snz_tmr  <= w_snz_tmr_n;
      r_snz_cnt  <= w_snz_cnt_n;
      r_beep     <= w_beep_n;
      r_set_en   <= (w_state_n == SET_HH) || (w_state_n == SET_MM);
      r_blink    <= w_blink_n;
      r_ringing  <= (w_state_n == RING);
      r_buzzer   <= (w_state_n == RING) && w_beep_n;
    end
  end

  assign alm_set_en = r_set_en;
  assign alm_hh     = r_alm_hh;
  assign alm_mm     = r_alm_mm;
  assign blink_sel  = r_blink;
  assign armed      = r_armed;
  assign ringing    = r_ringing;
  assign buzzer     = r_buzzer;
endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: setting sequence, BCD wrap, match/ring,
// snooze limits, stop priority, clk_set_en suppression and mid-ring reset.
module tb_alarm_controller;
  logic       clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [7:0] cur_hh = 8'h00, cur_mm = 8'h00, cur_ss = 8'h01;
  logic       clk_set_en = 1'b0, alm_p = 1'b0, sel_p = 1'b0, inc_p = 1'b0;
  logic       stop_p = 1'b0, snooze_p = 1'b0;
  logic       alm_set_en, armed, ringing, buzzer;
  logic [7:0] alm_hh, alm_mm;
  logic [1:0] blink_sel;
  int         n_chk = 0, n_fail = 0;

  alarm_controller dut (
    .clk(clk), .rst(rst), .clk_1hz_tick(tick),
    .cur_hh(cur_hh), .cur_mm(cur_mm), .cur_ss(cur_ss),
    .clk_set_en(clk_set_en), .alm_p(alm_p), .sel_p(sel_p), .inc_p(inc_p),
    .stop_p(stop_p), .snooze_p(snooze_p),
    .alm_set_en(alm_set_en), .alm_hh(alm_hh), .alm_mm(alm_mm),
    .blink_sel(blink_sel), .armed(armed), .ringing(ringing), .buzzer(buzzer)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 ns after an edge; outputs are sampled 1 ns after the next edge.
  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic ticks(input int n);
    repeat (n) begin tick = 1'b1; cyc(1); tick = 1'b0; cyc(1); end
  endtask

  task automatic press_alm(); alm_p = 1'b1; cyc(1); alm_p = 1'b0; endtask
  task automatic press_sel(); sel_p = 1'b1; cyc(1); sel_p = 1'b0; endtask
  task automatic press_inc(input int n);
    repeat (n) begin inc_p = 1'b1; cyc(1); inc_p = 1'b0; end
  endtask
  task automatic press_snz(); snooze_p = 1'b1; cyc(1); snooze_p = 1'b0; endtask

  // Rising match at 07:30:00, then move the seconds on so the match drops.
  task automatic hit_alarm();
    cur_hh = 8'h07; cur_mm = 8'h29; cur_ss = 8'h59; cyc(1);
    cur_mm = 8'h30; cur_ss = 8'h00; cyc(1);
    cur_ss = 8'h01;
  endtask

  initial begin
    cyc(2);
    rst = 1'b0;
    chk("rst_hh", alm_hh, 8'h00);
    chk("rst_mm", alm_mm, 8'h00);
    chk("rst_armed", armed, 0);
    chk("rst_set_en", alm_set_en, 0);
    chk("rst_blink", blink_sel, 2'b11);
    chk("rst_ring", ringing, 0);
    chk("rst_buzz", buzzer, 0);

    // Set 07:30 through the button sequence.
    press_alm();
    chk("set_en_hh", alm_set_en, 1);
    chk("blink_hh", blink_sel, 2'b00);
    press_inc(7);
    chk("hh_07", alm_hh, 8'h07);
    press_sel();
    chk("blink_mm", blink_sel, 2'b01);
    press_inc(30);
    chk("mm_30", alm_mm, 8'h30);
    press_alm();
    chk("armed_set", armed, 1);
    chk("set_en_off", alm_set_en, 0);
    chk("blink_none", blink_sel, 2'b11);

    // BCD wrap on both fields, then restore 07:30.
    press_alm();
    press_inc(16);
    chk("hh_23", alm_hh, 8'h23);
    press_inc(1);
    chk("hh_wrap", alm_hh, 8'h00);
    press_inc(7);
    press_sel();
    press_inc(29);
    chk("mm_59", alm_mm, 8'h59);
    press_inc(1);
    chk("mm_wrap", alm_mm, 8'h00);
    chk("mm_wrap_hh", alm_hh, 8'h07);
    press_inc(30);
    // sel beats inc; alm beats sel and inc.
    sel_p = 1'b1; inc_p = 1'b1; cyc(1); sel_p = 1'b0; inc_p = 1'b0;
    chk("pri_sel_blink", blink_sel, 2'b00);
    chk("pri_sel_mm", alm_mm, 8'h30);
    alm_p = 1'b1; sel_p = 1'b1; inc_p = 1'b1; cyc(1);
    alm_p = 1'b0; sel_p = 1'b0; inc_p = 1'b0;
    chk("pri_alm_set_en", alm_set_en, 0);
    chk("pri_alm_hh", alm_hh, 8'h07);

    // snooze_p in IDLE toggles armed.
    press_snz();
    chk("arm_toggle0", armed, 0);
    press_snz();
    chk("arm_toggle1", armed, 1);

    // Match -> RING, held match must not retrigger, auto-stop after 60 ticks.
    cur_hh = 8'h07; cur_mm = 8'h29; cur_ss = 8'h59; cyc(1);
    chk("pre_match", ringing, 0);
    cur_mm = 8'h30; cur_ss = 8'h00; cyc(1);
    chk("ring_on", ringing, 1);
    chk("buzz_1", buzzer, 1);
    ticks(1);
    chk("buzz_0", buzzer, 0);
    cyc(3);
    chk("no_retrig", buzzer, 0);
    cur_ss = 8'h01;
    ticks(1);
    chk("buzz_1b", buzzer, 1);
    ticks(57);
    chk("ring_59", ringing, 1);
    chk("buzz_59", buzzer, 0);
    ticks(1);
    chk("auto_stop", ringing, 0);
    chk("auto_stop_buzz", buzzer, 0);
    chk("auto_stop_armed", armed, 1);

    // Three snoozes allowed, the fourth is ignored.
    hit_alarm();
    chk("ring2", ringing, 1);
    for (int s = 0; s < 3; s++) begin
      press_snz();
      chk("snooze_ring", ringing, 0);
      chk("snooze_buzz", buzzer, 0);
      ticks(299);
      chk("snooze_299", ringing, 0);
      ticks(1);
      chk("rering", ringing, 1);
      chk("rering_buzz", buzzer, 1);
    end
    press_snz();
    chk("snooze_max", ringing, 1);
    stop_p = 1'b1; snooze_p = 1'b1; cyc(1); stop_p = 1'b0; snooze_p = 1'b0;
    chk("stop_over_snz", ringing, 0);
    ticks(2);
    chk("stop_stays", ringing, 0);
    chk("stop_armed", armed, 1);

    // stop beats a same-cycle snooze timeout; no re-ring afterwards.
    hit_alarm();
    press_snz();
    ticks(299);
    stop_p = 1'b1; tick = 1'b1; cyc(1); stop_p = 1'b0; tick = 1'b0; cyc(1);
    chk("stop_over_tick", ringing, 0);
    ticks(300);
    chk("no_rering", ringing, 0);

    // clk_set_en suppresses match and alm_p.
    clk_set_en = 1'b1;
    hit_alarm();
    chk("setclk_nomatch", ringing, 0);
    press_alm();
    chk("setclk_noalm", alm_set_en, 0);
    clk_set_en = 1'b0;

    // Reset mid-RING.
    hit_alarm();
    chk("ring_pre_rst", ringing, 1);
    rst = 1'b1; cyc(1);
    chk("mid_rst_ring", ringing, 0);
    chk("mid_rst_buzz", buzzer, 0);
    chk("mid_rst_hh", alm_hh, 8'h00);
    chk("mid_rst_mm", alm_mm, 8'h00);
    chk("mid_rst_armed", armed, 0);
    chk("mid_rst_blink", blink_sel, 2'b11);
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
